// File: rtl/instr_sequencer_if.sv
// Bundles the program-load, control, datapath and status signals of instr_sequencer.
// The sequencer takes the slave side; the controller or bench takes the master side.
interface instr_sequencer_if #(
    parameter int AW = 4
) ();
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          start;
    logic          abort;
    logic [7:0]    result_in;
    logic          zero_in;
    logic          carry_in;
    logic          overflow_in;
    logic [7:0]    instr_out;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          err_eop;
    logic          result_valid;
    logic [7:0]    last_result;
    logic [2:0]    last_flags;
    logic [7:0]    exec_count;

    modport master (
        output load_en, load_addr, load_data, start, abort,
               result_in, zero_in, carry_in, overflow_in,
        input  instr_out, pc, busy, halted, err_eop, result_valid,
               last_result, last_flags, exec_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, abort,
               result_in, zero_in, carry_in, overflow_in,
        output instr_out, pc, busy, halted, err_eop, result_valid,
               last_result, last_flags, exec_count
    );
endinterface

// File: rtl/instr_sequencer.sv
// Steps through a small byte-wide program memory, one instruction every three cycles
// (FETCH, ISSUE, EXEC), and captures the datapath result of each executed instruction.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_sequencer_if.slave bus
);
    localparam logic [7:0]    NOP_OP  = 8'hFF;
    localparam logic [7:0]    HALT_OP = 8'h13;
    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, EXEC, HALTED} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    ir;
    logic [AW-1:0] pc;
    logic          err_eop;
    logic          result_valid;
    logic [7:0]    last_result;
    logic [2:0]    last_flags;
    logic [7:0]    exec_count;
    logic          loadable;

    assign loadable = (state == IDLE) || (state == HALTED);

    // NOTE: the program store has no reset on purpose -- a program loaded once survives rst,
    // and leaving the array out of the reset tree keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus.load_en && loadable) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // NOTE: state_next is given its hold value before the case, so every path assigns it
    // and no latch can be inferred.
    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE, HALTED: if (bus.start) state_next = FETCH;
                FETCH:        state_next = ISSUE;
                ISSUE:        state_next = EXEC;
                EXEC:         state_next = (ir == HALT_OP || pc == LAST_PC) ? HALTED : FETCH;
                default:      state_next = IDLE;
            endcase
        end
    end

    // NOTE: all registered state below uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir           <= NOP_OP;
            pc           <= '0;
            err_eop      <= 1'b0;
            result_valid <= 1'b0;
            last_result  <= 8'h00;
            last_flags   <= 3'b000;
            exec_count   <= 8'h00;
        end else begin
            result_valid <= 1'b0;
            if (bus.abort) begin
                pc <= '0;
            end else begin
                unique case (state)
                    IDLE, HALTED: begin
                        if (bus.start) begin
                            pc         <= '0;
                            exec_count <= 8'h00;
                            err_eop    <= 1'b0;
                        end
                    end
                    FETCH: ir <= mem[pc];
                    ISSUE: begin
                        if (exec_count != 8'hFF) exec_count <= exec_count + 8'd1;
                    end
                    EXEC: begin
                        last_result  <= bus.result_in;
                        last_flags   <= {bus.overflow_in, bus.carry_in, bus.zero_in};
                        result_valid <= 1'b1;
                        // A program that runs off the last word stops there rather than wrapping.
                        if (ir != HALT_OP) begin
                            if (pc == LAST_PC) err_eop <= 1'b1;
                            else               pc      <= pc + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.instr_out    = (state == ISSUE || state == EXEC) ? ir : NOP_OP;
    assign bus.pc           = pc;
    assign bus.busy         = (state == FETCH) || (state == ISSUE) || (state == EXEC);
    assign bus.halted       = (state == HALTED);
    assign bus.err_eop      = err_eop;
    assign bus.result_valid = result_valid;
    assign bus.last_result  = last_result;
    assign bus.last_flags   = last_flags;
    assign bus.exec_count   = exec_count;
endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit program memory words (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, program address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_en  input  1  program-memory write strobe.
REQ-006 SHALL have port load_addr  input  AW  program-memory write address.
REQ-007 SHALL have port load_data  input  8  program-memory write data (one instruction byte).
REQ-008 SHALL have port start  input  1  begin execution at address 0.
REQ-009 SHALL have port abort  input  1  stop execution and return to IDLE.
REQ-010 SHALL have port result_in  input  8  datapath ALU result.
REQ-011 SHALL have port zero_in, carry_in, overflow_in  input  1 each  datapath ALU flags.
REQ-012 SHALL have port instr_out  output  8  instruction byte driven to the datapath instr input.
REQ-013 SHALL have port pc  output  AW  address of the instruction currently in flight.
REQ-014 SHALL have port busy  output  1  high in FETCH, ISSUE and EXEC.
REQ-015 SHALL have port halted  output  1  high in HALTED.
REQ-016 SHALL have port err_eop  output  1  end of program reached without a HALT.
REQ-017 SHALL have port result_valid  output  1  one-cycle pulse when last_result/flags update.
REQ-018 SHALL have port last_result  output  8  captured result_in.
REQ-019 SHALL have port last_flags  output  3  captured {overflow, carry, zero}.
REQ-020 SHALL have port exec_count  output  8  instructions issued since start, saturating at 8'hFF.

Function
REQ-021 SHALL implement states IDLE, FETCH, ISSUE, EXEC and HALTED.
REQ-022 IDLE: on start go to FETCH with pc=0; clear exec_count and err_eop.
REQ-023 FETCH: register mem[pc] into an internal instruction register ir; go to ISSUE.
REQ-024 ISSUE: instr_out=ir; increment exec_count (saturating); go to EXEC.
REQ-025 EXEC: hold instr_out=ir; the datapath result is combinationally valid this cycle.
REQ-026 EXEC edge: capture last_result<=result_in and last_flags<={overflow_in,carry_in,zero_in}; result_valid is high for exactly the next cycle.
REQ-027 EXEC exit, ir==8'h13 (HALT): go to HALTED; pc holds.
REQ-028 EXEC exit, otherwise with pc==DEPTH-1: go to HALTED with err_eop=1; pc holds (no wrap).
REQ-029 EXEC exit, otherwise: pc<=pc+1 and go to FETCH.
REQ-030 Throughput SHALL be 3 cycles per instruction; the first instr_out is valid 2 cycles after the start edge.
REQ-031 In IDLE, FETCH and HALTED, instr_out SHALL be 8'hFF (NOP).
REQ-032 HALTED: on start, restart exactly as from IDLE; otherwise remain in HALTED.
REQ-033 start SHALL be ignored in FETCH, ISSUE and EXEC.
REQ-034 load_en SHALL write mem[load_addr] only in IDLE or HALTED; it is ignored while busy.
REQ-035 Simultaneous load_en and start in IDLE: the write SHALL complete and execution starts; the first FETCH reads the updated memory.
REQ-036 abort in any state SHALL go to IDLE at the next edge, set pc=0 and instr_out=8'hFF, and suppress result_valid; abort has priority over start.

Reset
REQ-037 On rst, asynchronously: state=IDLE, pc=0, instr_out=8'hFF, busy=0, halted=0, err_eop=0, result_valid=0, last_result=0, last_flags=0, exec_count=0.
REQ-038 Program memory SHALL NOT be cleared by rst; rst asserted mid-instruction discards the instruction with no result_valid.

Verification
REQ-039 Reset: assert rst mid-run -> all outputs take REQ-037 values immediately, instr_out=8'hFF.
REQ-040 Load {00,01,13} at 0..2, then start -> instr_out=00 at start+2, 01 at start+5, 13 at start+8; then halted=1, exec_count=3, err_eop=0.
REQ-041 Drive result_in=8'h08 and zero_in=0 in the first EXEC -> last_result=8'h08, last_flags=3'b000, one result_valid pulse.
REQ-042 DEPTH=4, all words 8'h00, start -> 4 issues, then halted=1, err_eop=1, pc=3.
REQ-043 abort during the second ISSUE -> IDLE next cycle, pc=0, no result_valid; a start pulse in busy states and load_en while busy cause no effect.
REQ-044 Start from HALTED -> restarts at pc=0 with exec_count cleared.
